// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Serial bit-pattern transmitter. Sends a latched PAT_W-bit
//               pattern MSB-first on x_out, repeated reps times, with gap
//               idle-0 bits between repetitions. Reports busy/done and the
//               number of fully sent patterns.
// Ports       : clk        - system clock (rising edge)
//               rst        - asynchronous active-high reset
//               start      - burst request, only honoured while idle
//               pattern    - pattern to send (MSB first)
//               reps       - repetitions per burst (0 = request ignored)
//               gap        - idle-0 bits inserted between repetitions
//               x_out      - registered serial data
//               busy       - high while a burst is in progress
//               done       - one-cycle pulse when a burst completes
//               frame_cnt  - patterns fully sent in current/last burst
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_GAP   = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(PAT_W - 1);

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;       // pattern latched at burst start
    logic [PAT_W-1:0] r_shift;     // bits still to be emitted, next one at MSB
    logic [CNT_W-1:0] r_reps;
    logic [GAP_W-1:0] r_gap;
    logic [IDX_W-1:0] r_idx;       // position of the bit currently on x_out
    logic [GAP_W-1:0] r_gap_cnt;   // idle cycles left, including the current one

    logic [CNT_W-1:0] w_frame_next;

    // reps is never larger than 2^CNT_W-1, so this cannot wrap before it
    // matches r_reps and ends the burst.
    assign w_frame_next = frame_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= C_IDLE;
            r_pat     <= '0;
            r_shift   <= '0;
            r_reps    <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            x_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    x_out <= 1'b0;
                    busy  <= 1'b0;
                    if (start && (reps != '0)) begin
                        r_pat     <= pattern;
                        r_reps    <= reps;
                        r_gap     <= gap;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                        x_out     <= pattern[PAT_W-1];
                        r_shift   <= pattern << 1;
                        r_idx     <= C_LAST_IDX;
                        r_state   <= C_SHIFT;
                    end
                end

                C_SHIFT: begin
                    if (r_idx != '0) begin
                        x_out   <= r_shift[PAT_W-1];
                        r_shift <= r_shift << 1;
                        r_idx   <= r_idx - IDX_W'(1);
                    end else begin
                        // Bit 0 has just completed its cycle on the line.
                        frame_cnt <= w_frame_next;
                        if (w_frame_next == r_reps) begin
                            r_state <= C_IDLE;
                            x_out   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (r_gap != '0) begin
                            r_state   <= C_GAP;
                            x_out     <= 1'b0;
                            r_gap_cnt <= r_gap;
                        end else begin
                            // Back-to-back repetition, no idle cycle.
                            x_out   <= r_pat[PAT_W-1];
                            r_shift <= r_pat << 1;
                            r_idx   <= C_LAST_IDX;
                        end
                    end
                end

                C_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        x_out   <= r_pat[PAT_W-1];
                        r_shift <= r_pat << 1;
                        r_idx   <= C_LAST_IDX;
                        r_state <= C_SHIFT;
                    end else begin
                        x_out     <= 1'b0;
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    r_state <= C_IDLE;
                    x_out   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_tx
// Description : Self-checking bench for serial_pattern_tx. Expected line
//               values come from a positional model of the burst: cycle k of
//               a burst carries bit (PAT_W-1-off) of the pattern when
//               off = k mod (PAT_W+gap) is inside the pattern, else 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

    localparam int PAT_W = 3;
    localparam int CNT_W = 4;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frame_cnt;

    int n_checks   = 0;
    int n_errors   = 0;
    int last_frame = 0;

    serial_pattern_tx #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .reps     (reps),
        .gap      (gap),
        .x_out    (x_out),
        .busy     (busy),
        .done     (done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line value at cycle k of a burst.
    function automatic int exp_bit(input logic [PAT_W-1:0] pat, input int g, input int k);
        int off;
        off = k % (PAT_W + g);
        if (off < PAT_W) return int'(pat[PAT_W-1-off]);
        return 0;
    endfunction

    // Patterns whose last bit lies strictly before cycle k.
    function automatic int exp_frame(input int r, input int g, input int k);
        int n;
        n = 0;
        for (int i = 0; i < r; i++)
            if (i * (PAT_W + g) + PAT_W - 1 < k) n++;
        return n;
    endfunction

    // Called at a negedge; asserts start there, so the accepting edge is the
    // next posedge. Returns at the negedge of the done cycle with start low.
    task automatic run_burst(input logic [PAT_W-1:0] p, input int r, input int g, input bit meddle);
        int len;
        len     = r * PAT_W + (r - 1) * g;
        pattern = p;
        reps    = CNT_W'(r);
        gap     = GAP_W'(g);
        start   = 1'b1;
        @(negedge clk);
        for (int k = 0; k < len; k++) begin
            check_val("x_out", x_out, exp_bit(p, g, k));
            check_val("busy", busy, 1);
            check_val("done_low", done, 0);
            check_val("frame_cnt", frame_cnt, exp_frame(r, g, k));
            if (meddle && k < len - 1) begin
                start   = 1'($urandom);
                pattern = PAT_W'($urandom);
                reps    = CNT_W'($urandom);
                gap     = GAP_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check_val("done_pulse", done, 1);
        check_val("busy_end", busy, 0);
        check_val("x_out_end", x_out, 0);
        check_val("frame_final", frame_cnt, r);
        last_frame = r;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            check_val("idle_x", x_out, 0);
            check_val("idle_busy", busy, 0);
            check_val("idle_done", done, 0);
            check_val("idle_frame", frame_cnt, last_frame);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = '0;
        reps    = '0;
        gap     = '0;
        #12;
        check_val("rst_x", x_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_frame", frame_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // T1: back-to-back repetitions
        run_burst(3'b101, 2, 0, 1'b0);
        idle_cycles(1);

        // T2: gap between repetitions
        run_burst(3'b100, 2, 2, 1'b0);
        idle_cycles(1);

        // T3: zero repetitions is ignored
        pattern = 3'b101;
        reps    = '0;
        gap     = '0;
        start   = 1'b1;
        idle_cycles(3);
        start = 1'b0;
        idle_cycles(1);

        // T4: input changes and start while busy have no effect
        run_burst(3'b101, 3, 0, 1'b1);
        idle_cycles(1);

        // T5: asynchronous reset in the 2nd repetition
        pattern = 3'b101;
        reps    = 4'd3;
        gap     = 4'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("t5_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_rst_x", x_out, 0);
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_done", done, 0);
        check_val("t5_rst_frame", frame_cnt, 0);
        @(negedge clk);
        rst        = 1'b0;
        last_frame = 0;
        idle_cycles(1);
        run_burst(3'b101, 2, 1, 1'b0);
        idle_cycles(1);

        // T6: start present in the done cycle begins a new burst at once
        run_burst(3'b101, 1, 0, 1'b0);
        run_burst(3'b101, 1, 0, 1'b0);
        idle_cycles(1);

        // Boundaries: maximum reps and maximum gap
        run_burst(3'b011, 15, 1, 1'b0);
        idle_cycles(1);
        run_burst(3'b110, 2, 15, 1'b0);
        idle_cycles(1);

        // Randomized bursts, some chained, some with busy-time disturbance
        repeat (12) begin
            run_burst(PAT_W'($urandom), $urandom_range(1, 5), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
